pipe_result_collector: RTL and testbench

- Downstream companion of the 3-stage arithmetic pipeline (F = D*((A+B)+(C-D)), N bits, 3-cycle latency, no stall capability).
- Tracks which issued operand sets are real via a valid shift chain aligned to the pipeline latency.
- Captures the resulting F words into a small FIFO and presents them on a valid/ready output.
- Issues credit-based in_ready to the operand source, so results are never lost even though the pipeline cannot stall.

---
 rtl/pipe_result_collector.sv | 55 +++++
 tb/tb_pipe_result_collector.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_result_collector.sv
// pipe_result_collector: tracks valid results of a fixed-latency pipeline, buffers them in a FIFO, issues credits
module pipe_result_collector #(
  parameter int N     = 10,
  parameter int LAT   = 3,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N-1:0]                 pipe_f,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N-1:0]                 out_data,
  output logic [$clog2(LAT+1)-1:0]     inflight,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         ovf_err
);
  localparam int IW = $clog2(LAT+1);
  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);
  logic [LAT-1:0] vchain;
  logic [N-1:0]   mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic           accept, push, pop, drop, wr;
  assign accept    = in_valid && in_ready;
  assign push      = vchain[LAT-1];
  assign out_valid = count != '0;
  assign pop       = out_valid && out_ready;
  assign drop      = push && count == CW'(DEPTH) && !pop;
  assign wr        = push && !drop;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  // credits come from registered state only, so in_ready has no combinational input path
  assign in_ready  = (int'(count) + int'(inflight)) < DEPTH;
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LAT; i++) inflight = inflight + IW'(vchain[i]);
  end
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= pipe_f;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vchain  <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovf_err <= 1'b0;
    end else begin
      vchain  <= {vchain[LAT-2:0], accept};
      wr_ptr  <= wr ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr  <= pop ? rd_ptr + AW'(1) : rd_ptr;
      count   <= (wr && !pop) ? count + CW'(1) : (!wr && pop) ? count - CW'(1) : count;
      ovf_err <= ovf_err || drop || (in_valid && !in_ready);
    end
endmodule

// File: tb/tb_pipe_result_collector.sv
// tb_pipe_result_collector: random + directed bench with a queue-based reference model
module tb_pipe_result_collector;
  localparam int N = 10, LAT = 3, DEPTH = 4;
  logic clk = 0, rst_n = 1, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, ovf_err;
  logic [N-1:0] out_data, a = 0, b = 0, c = 0, d = 0;
  logic [N-1:0] p [LAT];
  logic [1:0] inflight;
  logic [2:0] count;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  pipe_result_collector #(.N(N), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .pipe_f(p[LAT-1]),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .inflight(inflight), .count(count), .ovf_err(ovf_err));
  function automatic logic [N-1:0] fcalc(input logic [N-1:0] fa, fb, fc, fd);
    return fd * ((fa + fb) + (fc - fd));
  endfunction
  // stand-in for the arithmetic pipeline: unreset, computes every cycle
  always @(posedge clk) begin
    p[0] <= fcalc(a, b, c, d);
    for (int i = 1; i < LAT; i++) p[i] <= p[i-1];
  end
  typedef struct { logic [N-1:0] v; int left; } inf_t;
  inf_t mq[$];
  logic [N-1:0] mf[$];
  logic [N-1:0] got[$];
  bit merr = 0, mrdy;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mq.delete(); mf.delete(); merr = 0;
    end else begin
      mrdy = (mf.size() + mq.size()) < DEPTH;
      if (mf.size() > 0 && out_ready) void'(mf.pop_front());
      if (in_valid && !mrdy) merr = 1;
      for (int i = 0; i < mq.size(); i++) mq[i].left--;
      if (mq.size() > 0 && mq[0].left == 0) begin
        if (mf.size() < DEPTH) mf.push_back(mq[0].v); else merr = 1;
        void'(mq.pop_front());
      end
      if (in_valid && mrdy) mq.push_back('{fcalc(a, b, c, d), LAT});
    end
  always @(posedge clk)
    if (rst_n && out_valid && out_ready) got.push_back(out_data);
  always @(negedge clk) begin
    logic [N+7:0] act, exp;
    act = {in_ready, out_valid, out_data, inflight, count, ovf_err};
    exp = {(mf.size() + mq.size()) < DEPTH, mf.size() > 0,
           mf.size() > 0 ? mf[0] : {N{1'b0}}, 2'(mq.size()), 3'(mf.size()), merr};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL cycle_compare t=%0t got=%h expected=%h", $time, act, exp);
    end
  end
  task automatic chk(input string nm, input int g, input int e);
    total++;
    if (g !== e) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", nm, g, e);
    end
  endtask
  task automatic cyc();
    @(negedge clk); #1;
  endtask
  task automatic single(input logic [N-1:0] sa, sb, sc, sd, input int e, input string nm);
    {a, b, c, d} = {sa, sb, sc, sd};
    in_valid = 1;
    cyc();
    in_valid = 0;
    repeat (2) @(negedge clk);
    chk({nm, "_early_valid"}, out_valid, 0);
    @(negedge clk);
    chk({nm, "_valid"}, out_valid, 1);
    chk({nm, "_data"}, out_data, e);
    chk({nm, "_count1"}, count, 1);
    #1 out_ready = 1;
    @(negedge clk);
    chk({nm, "_count0"}, count, 0);
    #1 out_ready = 0;
  endtask
  initial begin
    int acc, k;
    #1 rst_n = 0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    #1 rst_n = 1;
    single(5, 3, 7, 2, 26, "single");
    single(1000, 100, 0, 10, 660, "wrap");
    // back-pressure: source offers whenever it sees credit
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      {a, b, c, d} = {N'($urandom), N'($urandom), N'($urandom), N'($urandom)};
      in_valid = in_ready;
      if (in_valid) acc++;
      cyc();
    end
    in_valid = 0;
    chk("bp_accepts", acc, 4);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_credits", int'(count) + int'(inflight), 4);
    out_ready = 1;
    @(negedge clk);
    chk("bp_reassert", in_ready, 1);
    chk("bp_no_err", ovf_err, 0);
    repeat (6) cyc();
    // streaming D = 1..20
    got.delete();
    {a, b, c} = '0;
    k = 1;
    for (int i = 0; i < 200 && k <= 20; i++) begin
      d = N'(k);
      in_valid = in_ready;
      if (in_ready) k++;
      cyc();
    end
    in_valid = 0;
    repeat (8) cyc();
    chk("stream_n", got.size(), 20);
    if (got.size() == 20) begin
      chk("stream_0", got[0], 1023);
      chk("stream_1", got[1], 1020);
      chk("stream_2", got[2], 1015);
      chk("stream_19", got[19], 624);
    end
    // random legal traffic
    for (int i = 0; i < 3000; i++) begin
      {a, b, c, d} = {N'($urandom), N'($urandom), N'($urandom), N'($urandom)};
      in_valid = in_ready && $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      cyc();
    end
    in_valid = 0;
    out_ready = 1;
    repeat (8) cyc();
    // reset with 2 buffered and 2 in flight
    out_ready = 0;
    in_valid = 1;
    repeat (2) cyc();
    in_valid = 0;
    repeat (4) cyc();
    in_valid = 1;
    repeat (2) cyc();
    in_valid = 0;
    chk("mid_count", count, 2);
    chk("mid_inflight", inflight, 2);
    rst_n = 0;
    @(negedge clk);
    chk("mrst_valid", out_valid, 0);
    chk("mrst_count", count, 0);
    chk("mrst_inflight", inflight, 0);
    chk("mrst_in_ready", in_ready, 1);
    #1 rst_n = 1;
    got.delete();
    out_ready = 1;
    repeat (8) cyc();
    chk("mrst_no_stale", got.size(), 0);
    // illegal issue while out of credit
    out_ready = 0;
    for (int i = 0; i < 8; i++) begin
      in_valid = in_ready;
      cyc();
    end
    chk("ill_pre_err", ovf_err, 0);
    in_valid = 1;
    cyc();
    in_valid = 0;
    repeat (4) cyc();
    chk("ill_err", ovf_err, 1);
    chk("ill_count", count, 4);
    out_ready = 1;
    repeat (6) cyc();
    chk("ill_sticky", ovf_err, 1);
    chk("ill_drained", count, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
